// File: rtl/ppu_regs.sv
// ppu_regs: CPU-visible PPU register file ($2000-$3FFF, mirrored every 8 bytes).
// Holds control/mask/status, loopy scroll state, the PPUDATA read buffer and the NMI level.
module ppu_regs #(
  parameter int unsigned INC_DOWN = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic        rw,
  input  logic [7:0]  data_i,
  output logic [7:0]  data_o,
  output logic        nmi,
  input  logic        vblank_set,
  input  logic        vblank_clr,
  input  logic        spr0_hit,
  input  logic        spr_ovf,
  output logic [7:0]  ctrl,
  output logic [7:0]  mask,
  output logic [14:0] t_addr,
  output logic [14:0] v_addr,
  output logic [2:0]  fine_x,
  output logic        vram_rd,
  output logic        vram_wr,
  output logic [13:0] vram_addr,
  output logic [7:0]  vram_wdata,
  input  logic [7:0]  vram_rdata
);
  localparam int unsigned VW = 15;
  localparam int unsigned AW = 14;

  logic          wr_acc, rd_acc, stat_rd;
  logic [2:0]    sel;
  logic [VW-1:0] inc;
  logic          w, vblank, rd_pend;
  logic [7:0]    io_latch, rd_buf;
  logic          unused_addr;

  logic [7:0]    ctrl_n, mask_n, io_n, rd_buf_n, vram_wdata_n;
  logic [VW-1:0] t_n, v_n;
  logic [2:0]    fine_x_n;
  logic          w_n, vblank_n, nmi_n, vram_rd_n, vram_wr_n, rd_pend_n;
  logic [AW-1:0] vram_addr_n;

  assign sel         = addr[2:0];
  assign wr_acc      = (addr[15:13] == 3'b001) && !rw;
  assign rd_acc      = (addr[15:13] == 3'b001) && rw;
  assign inc         = ctrl[2] ? VW'(INC_DOWN) : VW'(1);
  assign unused_addr = ^addr[12:3];

  // Read mux reflects the state before this cycle's access takes effect.
  always_comb begin
    data_o = 8'h00;
    if (rd_acc) begin
      case (sel)
        3'd0:    data_o = ctrl;
        3'd1:    data_o = mask;
        3'd2:    data_o = {vblank, spr0_hit, spr_ovf, io_latch[4:0]};
        3'd7:    data_o = rd_buf;
        default: data_o = io_latch;
      endcase
    end
  end

  // Next-state: register writes, read side effects, vblank/NMI and VRAM strobes.
  always_comb begin
    ctrl_n       = ctrl;
    mask_n       = mask;
    t_n          = t_addr;
    v_n          = v_addr;
    fine_x_n     = fine_x;
    w_n          = w;
    io_n         = io_latch;
    stat_rd      = 1'b0;
    vram_rd_n    = 1'b0;
    vram_wr_n    = 1'b0;
    vram_addr_n  = vram_addr;
    vram_wdata_n = vram_wdata;
    rd_pend_n    = vram_rd;
    rd_buf_n     = rd_pend ? vram_rdata : rd_buf;

    if (wr_acc) begin
      io_n = data_i;
      case (sel)
        3'd0: begin
          ctrl_n       = data_i;
          t_n[11:10]   = data_i[1:0];
        end
        3'd1: mask_n = data_i;
        3'd5: begin
          if (!w) begin
            t_n[4:0]   = data_i[7:3];
            fine_x_n   = data_i[2:0];
            w_n        = 1'b1;
          end else begin
            t_n[14:12] = data_i[2:0];
            t_n[9:5]   = data_i[7:3];
            w_n        = 1'b0;
          end
        end
        3'd6: begin
          if (!w) begin
            t_n[13:8]  = data_i[5:0];
            t_n[14]    = 1'b0;
            w_n        = 1'b1;
          end else begin
            t_n[7:0]   = data_i;
            v_n        = t_n;
            w_n        = 1'b0;
          end
        end
        3'd7: begin
          vram_wr_n    = 1'b1;
          vram_addr_n  = v_addr[AW-1:0];
          vram_wdata_n = data_i;
          v_n          = v_addr + inc;
        end
        default: ;
      endcase
    end

    if (rd_acc) begin
      case (sel)
        3'd2: begin
          stat_rd      = 1'b1;
          w_n          = 1'b0;
        end
        3'd7: begin
          vram_rd_n    = 1'b1;
          vram_addr_n  = v_addr[AW-1:0];
          v_n          = v_addr + inc;
        end
        default: ;
      endcase
    end

    // Clear (pulse or status read) beats a coincident set, suppressing that NMI.
    vblank_n = (vblank | vblank_set) & ~vblank_clr & ~stat_rd;
    nmi_n    = ctrl_n[7] & vblank_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl       <= 8'h00;
      mask       <= 8'h00;
      t_addr     <= '0;
      v_addr     <= '0;
      fine_x     <= 3'd0;
      w          <= 1'b0;
      vblank     <= 1'b0;
      io_latch   <= 8'h00;
      rd_buf     <= 8'h00;
      rd_pend    <= 1'b0;
      nmi        <= 1'b0;
      vram_rd    <= 1'b0;
      vram_wr    <= 1'b0;
      vram_addr  <= '0;
      vram_wdata <= 8'h00;
    end else begin
      ctrl       <= ctrl_n;
      mask       <= mask_n;
      t_addr     <= t_n;
      v_addr     <= v_n;
      fine_x     <= fine_x_n;
      w          <= w_n;
      vblank     <= vblank_n;
      io_latch   <= io_n;
      rd_buf     <= rd_buf_n;
      rd_pend    <= rd_pend_n;
      nmi        <= nmi_n;
      vram_rd    <= vram_rd_n;
      vram_wr    <= vram_wr_n;
      vram_addr  <= vram_addr_n;
      vram_wdata <= vram_wdata_n;
    end
  end

endmodule

// File: tb/tb_ppu_regs.sv
// tb_ppu_regs: directed vector table, hand-written corner sequences and a random
// run against an arithmetic model of the PPU register file.
module tb_ppu_regs;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr;
  logic        rw;
  logic [7:0]  data_i, data_o, ctrl, mask, vram_wdata, vram_rdata;
  logic        nmi, vblank_set, vblank_clr, spr0_hit, spr_ovf, vram_rd, vram_wr;
  logic [14:0] t_addr, v_addr;
  logic [2:0]  fine_x;
  logic [13:0] vram_addr;

  always #5 clk = ~clk;

  ppu_regs #(.INC_DOWN(32)) dut (
    .clk(clk), .rst(rst), .addr(addr), .rw(rw), .data_i(data_i), .data_o(data_o),
    .nmi(nmi), .vblank_set(vblank_set), .vblank_clr(vblank_clr),
    .spr0_hit(spr0_hit), .spr_ovf(spr_ovf), .ctrl(ctrl), .mask(mask),
    .t_addr(t_addr), .v_addr(v_addr), .fine_x(fine_x), .vram_rd(vram_rd),
    .vram_wr(vram_wr), .vram_addr(vram_addr), .vram_wdata(vram_wdata),
    .vram_rdata(vram_rdata)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] do_s;

  // VRAM contents as a fixed function of address.
  function automatic int vf(input int a);
    return (((a & 255) * 3) + (a >> 8) + 'h55) & 255;
  endfunction

  // VRAM responder: data valid only in the cycle after the vram_rd strobe.
  logic        pend = 1'b0;
  logic [13:0] pend_addr = '0;
  always @(negedge clk) begin
    if (pend) vram_rdata = 8'(vf(int'(pend_addr)));
    else      vram_rdata = 8'hEE;
    pend      = vram_rd;
    pend_addr = vram_addr;
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One bus cycle: drive, sample data_o mid-cycle, return idle just after the edge.
  task automatic cyc(input logic [15:0] a, input logic r, input logic [7:0] d,
                     input logic vs, input logic vc);
    addr = a; rw = r; data_i = d; vblank_set = vs; vblank_clr = vc;
    @(negedge clk);
    do_s = data_o;
    @(posedge clk);
    #1;
    addr = 16'h0000; rw = 1'b1; data_i = 8'h00; vblank_set = 1'b0; vblank_clr = 1'b0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    cyc(a, 1'b0, d, 1'b0, 1'b0);
  endtask
  task automatic rd(input logic [15:0] a);
    cyc(a, 1'b1, 8'h00, 1'b0, 1'b0);
  endtask
  task automatic idle();
    cyc(16'h0000, 1'b1, 8'h00, 1'b0, 1'b0);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic [15:0] a;
    logic        r;
    logic [7:0]  d;
    logic        chk;
    logic [7:0]  exp_do;
    logic [7:0]  exp_ctrl;
    logic [14:0] exp_t;
    logic [14:0] exp_v;
    logic [2:0]  exp_fx;
  } vec_t;
  vec_t vecs[15];

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int m_ctrl, m_mask, m_t, m_v, m_fx, m_w, m_vbl, m_io, m_buf, m_nbuf;
    vecs[0]  = '{16'h2000, 1'b0, 8'h90, 1'b0, 8'h00, 8'h90, 15'h0000, 15'h0000, 3'd0};
    vecs[1]  = '{16'h2000, 1'b1, 8'h00, 1'b1, 8'h90, 8'h90, 15'h0000, 15'h0000, 3'd0};
    vecs[2]  = '{16'h3FF8, 1'b1, 8'h00, 1'b1, 8'h90, 8'h90, 15'h0000, 15'h0000, 3'd0};
    vecs[3]  = '{16'h2005, 1'b0, 8'h7D, 1'b0, 8'h00, 8'h90, 15'h000F, 15'h0000, 3'd5};
    vecs[4]  = '{16'h2005, 1'b0, 8'h5E, 1'b0, 8'h00, 8'h90, 15'h616F, 15'h0000, 3'd5};
    vecs[5]  = '{16'h2006, 1'b0, 8'h21, 1'b0, 8'h00, 8'h90, 15'h216F, 15'h0000, 3'd5};
    vecs[6]  = '{16'h2006, 1'b0, 8'h08, 1'b0, 8'h00, 8'h90, 15'h2108, 15'h2108, 3'd5};
    vecs[7]  = '{16'h2007, 1'b0, 8'hAB, 1'b0, 8'h00, 8'h90, 15'h2108, 15'h2109, 3'd5};
    vecs[8]  = '{16'h2000, 1'b0, 8'h07, 1'b0, 8'h00, 8'h07, 15'h2D08, 15'h2109, 3'd5};
    vecs[9]  = '{16'h2007, 1'b0, 8'hCD, 1'b0, 8'h00, 8'h07, 15'h2D08, 15'h2129, 3'd5};
    vecs[10] = '{16'h2003, 1'b1, 8'h00, 1'b1, 8'hCD, 8'h07, 15'h2D08, 15'h2129, 3'd5};
    vecs[11] = '{16'h2001, 1'b0, 8'h1E, 1'b0, 8'h00, 8'h07, 15'h2D08, 15'h2129, 3'd5};
    vecs[12] = '{16'h3FF9, 1'b1, 8'h00, 1'b1, 8'h1E, 8'h07, 15'h2D08, 15'h2129, 3'd5};
    vecs[13] = '{16'h4000, 1'b0, 8'hFF, 1'b0, 8'h00, 8'h07, 15'h2D08, 15'h2129, 3'd5};
    vecs[14] = '{16'h2002, 1'b1, 8'h00, 1'b1, 8'h1E, 8'h07, 15'h2D08, 15'h2129, 3'd5};

    addr = 16'h0000; rw = 1'b1; data_i = 8'h00; vblank_set = 1'b0; vblank_clr = 1'b0;
    spr0_hit = 1'b0; spr_ovf = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // Reset state
    check("rst ctrl", int'(ctrl), 0);
    check("rst mask", int'(mask), 0);
    check("rst t", int'(t_addr), 0);
    check("rst v", int'(v_addr), 0);
    check("rst fine_x", int'(fine_x), 0);
    check("rst nmi", int'(nmi), 0);
    check("rst vram_rd", int'(vram_rd), 0);
    check("rst vram_wr", int'(vram_wr), 0);
    check("rst vram_addr", int'(vram_addr), 0);
    check("rst vram_wdata", int'(vram_wdata), 0);
    rd(16'h2002);
    check("rst status", int'(do_s), 0);
    rd(16'h2007);
    check("rst rd_buf", int'(do_s), 0);
    do_reset();

    // Directed vector table
    for (int i = 0; i < 15; i++) begin
      cyc(vecs[i].a, vecs[i].r, vecs[i].d, 1'b0, 1'b0);
      if (vecs[i].chk) check($sformatf("vec%0d data_o", i), int'(do_s), int'(vecs[i].exp_do));
      check($sformatf("vec%0d ctrl", i), int'(ctrl), int'(vecs[i].exp_ctrl));
      check($sformatf("vec%0d t", i), int'(t_addr), int'(vecs[i].exp_t));
      check($sformatf("vec%0d v", i), int'(v_addr), int'(vecs[i].exp_v));
      check($sformatf("vec%0d fine_x", i), int'(fine_x), int'(vecs[i].exp_fx));
      idle();
      idle();
    end

    // VRAM write strobe timing and increment modes
    wr(16'h2000, 8'h00);
    wr(16'h2006, 8'h21);
    wr(16'h2006, 8'h08);
    wr(16'h2007, 8'hAB);
    check("wr strobe", int'(vram_wr), 1);
    check("wr addr", int'(vram_addr), 'h2108);
    check("wr data", int'(vram_wdata), 'hAB);
    check("wr v inc1", int'(v_addr), 'h2109);
    idle();
    check("wr strobe one cycle", int'(vram_wr), 0);
    check("wr data held", int'(vram_wdata), 'hAB);
    wr(16'h2000, 8'h04);
    wr(16'h2007, 8'hEF);
    check("wr addr2", int'(vram_addr), 'h2109);
    check("wr v inc32", int'(v_addr), 'h2129);

    // Read buffer latency
    wr(16'h2000, 8'h00);
    wr(16'h2006, 8'h20);
    wr(16'h2006, 8'h00);
    rd(16'h2007);
    check("rd1 old buf", int'(do_s), 0);
    check("rd1 strobe", int'(vram_rd), 1);
    check("rd1 addr", int'(vram_addr), 'h2000);
    rd(16'h2007);
    check("rd2 before capture", int'(do_s), 0);
    check("rd2 addr", int'(vram_addr), 'h2001);
    idle();
    rd(16'h2007);
    check("rd3 buffered", int'(do_s), vf('h2000));
    idle();
    idle();
    rd(16'h2007);
    check("rd4 buffered", int'(do_s), vf('h2002));
    idle();
    idle();

    // Vblank / NMI
    wr(16'h2000, 8'h80);
    check("nmi idle", int'(nmi), 0);
    cyc(16'h0000, 1'b1, 8'h00, 1'b1, 1'b0);
    check("nmi rise", int'(nmi), 1);
    rd(16'h2002);
    check("status vbl set", int'(do_s[7]), 1);
    check("nmi fall on read", int'(nmi), 0);
    rd(16'h2002);
    check("status vbl cleared", int'(do_s[7]), 0);
    cyc(16'h2002, 1'b1, 8'h00, 1'b1, 1'b0);
    check("suppress read bit7", int'(do_s[7]), 0);
    check("suppress nmi", int'(nmi), 0);
    idle();
    check("suppress nmi later", int'(nmi), 0);
    rd(16'h2002);
    check("suppress flag", int'(do_s[7]), 0);
    cyc(16'h0000, 1'b1, 8'h00, 1'b1, 1'b1);
    check("set+clr nmi", int'(nmi), 0);
    rd(16'h2002);
    check("set+clr flag", int'(do_s[7]), 0);
    wr(16'h2000, 8'h00);
    cyc(16'h0000, 1'b1, 8'h00, 1'b1, 1'b0);
    check("nmi masked", int'(nmi), 0);
    wr(16'h2000, 8'h80);
    check("nmi on ctrl write", int'(nmi), 1);
    wr(16'h2000, 8'h00);
    check("nmi ctrl cleared", int'(nmi), 0);
    wr(16'h2000, 8'h80);
    check("nmi retrigger", int'(nmi), 1);
    cyc(16'h0000, 1'b1, 8'h00, 1'b0, 1'b1);
    check("nmi vblank_clr", int'(nmi), 0);
    spr0_hit = 1'b1;
    rd(16'h2002);
    check("status spr0", int'(do_s), 'h40);
    spr0_hit = 1'b0; spr_ovf = 1'b1;
    rd(16'h2002);
    check("status ovf", int'(do_s), 'h20);
    spr_ovf = 1'b0;

    // Status read resets the write toggle
    wr(16'h2005, 8'hFF);
    rd(16'h2002);
    wr(16'h2005, 8'h10);
    check("toggle coarse x", int'(t_addr[4:0]), 2);
    check("toggle fine x", int'(fine_x), 0);

    // v wrap with +1 and +32
    rd(16'h2002);
    wr(16'h2000, 8'h04);
    wr(16'h2006, 8'h3F);
    wr(16'h2006, 8'hFF);
    repeat (512) wr(16'h2007, 8'h00);
    check("v reach 7FFF", int'(v_addr), 'h7FFF);
    wr(16'h2000, 8'h00);
    wr(16'h2007, 8'h11);
    check("wrap1 vram_addr", int'(vram_addr), 'h3FFF);
    check("wrap1 v", int'(v_addr), 0);
    wr(16'h2000, 8'h04);
    wr(16'h2006, 8'h3F);
    wr(16'h2006, 8'hF0);
    repeat (512) wr(16'h2007, 8'h00);
    check("v reach 7FF0", int'(v_addr), 'h7FF0);
    wr(16'h2007, 8'h22);
    check("wrap32 vram_addr", int'(vram_addr), 'h3FF0);
    check("wrap32 v", int'(v_addr), 'h0010);

    // Reset mid-sequence cancels strobes and the toggle
    wr(16'h2005, 8'h08);
    rst = 1'b1;
    wr(16'h2007, 8'h33);
    rst = 1'b0;
    check("rst cancels vram_wr", int'(vram_wr), 0);
    check("rst clears v", int'(v_addr), 0);
    wr(16'h2005, 8'h10);
    check("rst clears toggle", int'(t_addr[4:0]), 2);
    wr(16'h2006, 8'h20);
    wr(16'h2006, 8'h00);
    rd(16'h2007);
    rst = 1'b1;
    idle();
    rst = 1'b0;
    idle();
    idle();
    rd(16'h2007);
    check("rst cancels capture", int'(do_s), 0);

    // Random accesses against the model
    do_reset();
    m_ctrl = 0; m_mask = 0; m_t = 0; m_v = 0; m_fx = 0; m_w = 0;
    m_vbl = 0; m_io = 0; m_buf = 0; m_nbuf = 0;
    for (int k = 0; k < 400; k++) begin
      logic [15:0] a;
      logic r, vs, vc;
      logic [7:0] d;
      int ia, id, sel, inc, exp_do, ew, er, eva, ewd, rd2, dec;
      case ($urandom_range(0, 7))
        0:       a = 16'($urandom_range(0, 32'h1FFF));
        1:       a = 16'(32'h4000 + $urandom_range(0, 32'hBFFF));
        default: a = 16'(32'h2000 + $urandom_range(0, 1023) * 8 + $urandom_range(0, 7));
      endcase
      r = 1'($urandom_range(0, 1));
      d = 8'($urandom);
      vs = ($urandom_range(0, 5) == 0);
      vc = ($urandom_range(0, 9) == 0);
      spr0_hit = 1'($urandom_range(0, 1));
      spr_ovf  = 1'($urandom_range(0, 1));
      ia = int'(a); id = int'(d); sel = ia % 8;
      dec = ((ia >> 13) == 1) ? 1 : 0;
      inc = ((m_ctrl & 4) != 0) ? 32 : 1;
      exp_do = 0; ew = 0; er = 0; eva = 0; ewd = 0; rd2 = 0;
      if (dec == 1 && !r) begin
        m_io = id;
        case (sel)
          0: begin m_ctrl = id; m_t = (m_t & ~('h3 << 10)) | ((id & 3) << 10); end
          1: m_mask = id;
          5: if (m_w == 0) begin
               m_t = (m_t & ~31) | (id >> 3); m_fx = id & 7; m_w = 1;
             end else begin
               m_t = (m_t & ~(7 << 12) & ~(31 << 5)) | ((id & 7) << 12) | ((id >> 3) << 5);
               m_w = 0;
             end
          6: if (m_w == 0) begin
               m_t = (m_t & 'hFF) | ((id & 63) << 8); m_w = 1;
             end else begin
               m_t = (m_t & 'h7F00) | id; m_v = m_t; m_w = 0;
             end
          7: begin ew = 1; eva = m_v % 16384; ewd = id; m_v = (m_v + inc) % 32768; end
          default: ;
        endcase
      end
      if (dec == 1 && r) begin
        case (sel)
          0: exp_do = m_ctrl;
          1: exp_do = m_mask;
          2: begin
               exp_do = m_vbl * 128 + int'(spr0_hit) * 64 + int'(spr_ovf) * 32 + (m_io % 32);
               rd2 = 1; m_w = 0;
             end
          7: begin
               exp_do = m_buf; er = 1; eva = m_v % 16384;
               m_nbuf = vf(eva); m_v = (m_v + inc) % 32768;
             end
          default: exp_do = m_io;
        endcase
      end
      if (vc || rd2 == 1) m_vbl = 0;
      else if (vs) m_vbl = 1;

      cyc(a, r, d, vs, vc);
      if (dec == 1 && r) check($sformatf("rnd%0d data_o a=%h", k, a), int'(do_s), exp_do);
      check($sformatf("rnd%0d ctrl", k), int'(ctrl), m_ctrl);
      check($sformatf("rnd%0d mask", k), int'(mask), m_mask);
      check($sformatf("rnd%0d t", k), int'(t_addr), m_t);
      check($sformatf("rnd%0d v", k), int'(v_addr), m_v);
      check($sformatf("rnd%0d fine_x", k), int'(fine_x), m_fx);
      check($sformatf("rnd%0d nmi", k), int'(nmi), ((m_ctrl & 'h80) != 0 && m_vbl == 1) ? 1 : 0);
      check($sformatf("rnd%0d vram_wr", k), int'(vram_wr), ew);
      check($sformatf("rnd%0d vram_rd", k), int'(vram_rd), er);
      if (ew == 1 || er == 1) check($sformatf("rnd%0d vram_addr", k), int'(vram_addr), eva);
      if (ew == 1) check($sformatf("rnd%0d vram_wdata", k), int'(vram_wdata), ewd);
      idle();
      check($sformatf("rnd%0d strobes low", k), int'(vram_wr) + int'(vram_rd), 0);
      idle();
      if (er == 1) m_buf = m_nbuf;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ppu_regs.md
# ppu_regs

CPU-facing register file of the PPU: decodes CPU bus accesses to $2000-$3FFF (mirrored every 8 bytes), holds PPUCTRL/PPUMASK/PPUSTATUS, the loopy scroll/address registers (v, t, fine x, write toggle w), and the PPUDATA read buffer, and drives NMI. It sits directly downstream of the CPU (or the CPU bus-master testbench model) and upstream of the renderer and VRAM arbiter, which consume its control, scroll and VRAM-access outputs.

## Interface
Parameters:
- INC_DOWN, 32 — PPUDATA address increment when PPUCTRL[2]=1 (increment is 1 otherwise).

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- addr  in  16  CPU address; valid access every cycle addr[15:13]==3'b001
- rw  in  1  1=read, 0=write
- data_i  in  8  CPU write data
- data_o  out  8  CPU read data, combinational from addr/state in the access cycle
- nmi  out  1  level NMI = ctrl[7] & vblank flag (registered)
- vblank_set  in  1  one-cycle pulse from timing gen (scanline 241, dot 1)
- vblank_clr  in  1  one-cycle pulse (pre-render line, dot 1)
- spr0_hit, spr_ovf  in  1 each  status levels from renderer
- ctrl  out  8  PPUCTRL
- mask  out  8  PPUMASK
- t_addr  out  15  loopy t
- v_addr  out  15  loopy v
- fine_x  out  3  fine X scroll
- vram_rd, vram_wr  out  1 each  one-cycle VRAM strobes
- vram_addr  out  14  VRAM address
- vram_wdata  out  8  VRAM write data
- vram_rdata  in  8  VRAM read data, valid the cycle after vram_rd

## Operation
- Register select = addr[2:0]; no access when addr[15:13]!=3'b001 (idle bus addr=0 is ignored).
- Writes (state updates at next edge); every write also loads io_latch<=data_i:
  - 0 ctrl<=d; t[11:10]<=d[1:0].
  - 1 mask<=d.
  - 5 w=0: t[4:0]<=d[7:3], fine_x<=d[2:0], w<=1. w=1: t[14:12]<=d[2:0], t[9:5]<=d[7:3], w<=0.
  - 6 w=0: t[13:8]<=d[5:0], t[14]<=0, w<=1. w=1: t[7:0]<=d, v<=new t, w<=0.
  - 7 vram write of d at v[13:0]; v<=(v+inc) mod 2^15.
  - 2,3,4: io_latch only.
- Reads (data_o):
  - 0 ctrl; 1 mask (readback supported; CPU model polls ctrl for readiness).
  - 2 {vblank, spr0_hit, spr_ovf, io_latch[4:0]}; side effect: vblank<=0, w<=0.
  - 7 rd_buf; side effect: vram read at v[13:0], v<=(v+inc) mod 2^15.
  - 3,4,5,6 io_latch.
- Vblank flag: set by vblank_set, cleared by vblank_clr or $2002 read.
- nmi register <= ctrl_next[7] & vblank_next; writing ctrl[7]=1 while vblank is set raises nmi (re-trigger is the CPU's edge detect).

## Timing
- Reset: ctrl, mask, t, v, fine_x, w, vblank, io_latch, rd_buf = 0; nmi, vram_rd, vram_wr = 0; vram_addr, vram_wdata = 0.
- data_o combinational, same cycle as access; reflects pre-access state.
- vram_wr/vram_rd asserted exactly one cycle, the cycle after the $2007 access, with vram_addr = v before increment; vram_wdata held with it.
- rd_buf <= vram_rdata at end of the cycle after vram_rd (access N, strobe N+1, capture edge end of N+2). A $2007 read before capture returns the older buffer value.
- nmi rises one cycle after vblank_set (ctrl[7]=1); falls one cycle after $2002 read, vblank_clr, or ctrl[7] cleared.
- Simultaneous: vblank_set+vblank_clr → clear wins. vblank_set+$2002 read same cycle → read returns bit7=0, flag stays 0, no NMI (suppression). $2002 read and w update same cycle impossible (one access/cycle).
- v increment wraps 0x7FFF→0x0000 (+1) and 0x7FF0→0x0010 (+32); vram_addr drops v[14].
- rst mid-sequence (e.g. after first $2005 write) returns w=0; pending vram strobes cancelled.

## Test plan
- Reset, write $2000=0x90, read $2000 same-cycle → data_o=0x90 next read; ctrl=0x90, t[11:10]=0.
- Write $2005=0x7D then 0x5E → fine_x=5, t[4:0]=0x0F, t[9:5]=0x0B, t[14:12]=6, w=0.
- Write $2006=0x21, $2006=0x08 → v=t=0x2108; write $2007=0xAB → vram_wr one cycle, vram_addr=0x2108, data 0xAB, v=0x2109; with ctrl[2]=1 next write → v=0x2129.
- $2007 read at v=0x2000 with vram_rdata=0x55 → first read returns old rd_buf (0), vram_rd at 0x2000; read after ≥2 cycles returns 0x55.
- ctrl=0x80, vblank_set pulse → nmi=1 next cycle; $2002 read returns bit7=1 then nmi=0, second read bit7=0; vblank_set coincident with $2002 read → returns bit7=0, nmi stays 0.
- $2005 single write then $2002 read → w=0; next $2005=0x10 lands in coarse X (t[4:0]=2).
